// File: rtl/templatized_alu_sequencer_if.sv
// templatized_alu_sequencer_if
// Bundles the opcode issue handshake and the execution status outputs of
// templatized_alu_sequencer. The master side offers opcodes and may flush.
// The slave side is the sequencer itself.
//
// Handshake: an opcode transfers on a rising clk edge where in_valid and
// in_ready are both high. in_valid may be held high across cycles where
// in_ready is low; nothing happens until in_ready rises. in_ready is low
// whenever flush is high, so a flush always wins over a simultaneous offer.
interface templatized_alu_sequencer_if #(
  parameter int OP_W  = 3,
  parameter int CNT_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op_code;
  logic            flush;
  logic [1:0]      en;
  logic [OP_W-1:0] op_q;
  logic            busy;
  logic            done;
  logic            illegal;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, op_code, flush,
    input  in_ready, en, op_q, busy, done, illegal, op_count
  );

  modport slave (
    input  in_valid, op_code, flush,
    output in_ready, en, op_q, busy, done, illegal, op_count
  );
endinterface

// File: rtl/templatized_alu_sequencer.sv
// templatized_alu_sequencer
// Issues opcodes to two execution groups: the logic group (XOR, 1 cycle)
// and the shift group (SLL/SAR/ROTL/ROTR, SHIFT_CYCLES cycles). An accepted
// legal opcode drives a one-hot group enable for the whole execution length,
// with done on the last cycle. A new opcode may be accepted on the done
// cycle, so back-to-back operations run without an idle bubble. Illegal
// opcodes are accepted, dropped, and flagged with a one-cycle illegal pulse.
// flush aborts whatever is in flight.
//
// Optional feature: define ALU_SEQ_PERF_EN to build a saturating count of
// completed operations on op_count. Without it op_count is tied to zero.
module templatized_alu_sequencer #(
  parameter int OP_W         = 3,
  parameter int SHIFT_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  templatized_alu_sequencer_if.slave bus,
  output logic                       state_dbg
);

  // Remaining-cycle counter wide enough to hold SHIFT_CYCLES.
  localparam int CW = $clog2(SHIFT_CYCLES + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(SHIFT_CYCLES - 1);
  localparam logic          SHIFT_ONE  = (SHIFT_CYCLES == 1);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      en_q;
  logic [OP_W-1:0] op_q_r;
  logic            busy_q;
  logic            done_q;
  logic            illegal_q;
  logic            accept;
  logic            is_logic;
  logic            is_shift;

  // Opcode decode: 0 is XOR, 1..4 are the shifts, anything else is illegal.
  assign is_logic = (bus.op_code == OP_W'(0));
  assign is_shift = (bus.op_code >= OP_W'(1)) && (bus.op_code <= OP_W'(4));

  // Ready when idle or finishing; flush blocks acceptance outright.
  assign bus.in_ready = !bus.flush && ((state == IDLE) || done_q);
  assign accept       = bus.in_valid && bus.in_ready;

  // Sequencer FSM: all status outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      en_q      <= 2'b00;
      op_q_r    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (bus.flush) begin
      // Abort: drop the in-flight op, no done or illegal pulse follows.
      state     <= IDLE;
      cnt       <= '0;
      en_q      <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (accept && (is_logic || is_shift)) begin
        // Legal issue, either from IDLE or chained on a done cycle.
        state  <= EXEC;
        busy_q <= 1'b1;
        op_q_r <= bus.op_code;
        if (is_logic) begin
          en_q   <= 2'b10;
          cnt    <= '0;
          done_q <= 1'b1;
        end else begin
          en_q   <= 2'b01;
          cnt    <= SHIFT_LAST;
          done_q <= SHIFT_ONE;
        end
      end else if (accept) begin
        // Illegal opcode: consumed, flagged, nothing executes.
        state     <= IDLE;
        cnt       <= '0;
        en_q      <= 2'b00;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
        illegal_q <= 1'b1;
      end else if ((state == EXEC) && !done_q) begin
        // Mid-execution: count down, raise done for the final cycle.
        cnt    <= cnt - CW'(1);
        done_q <= (cnt == CW'(1));
      end else if (state == EXEC) begin
        // Last cycle passed with no follow-on op.
        state  <= IDLE;
        cnt    <= '0;
        en_q   <= 2'b00;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [CNT_W-1:0] op_count_q;

  // Count each done pulse, holding at all-ones; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (done_q && (op_count_q != {CNT_W{1'b1}})) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign bus.op_count = op_count_q;
`else
  assign bus.op_count = {CNT_W{1'b0}};
`endif

  assign bus.en      = en_q;
  assign bus.op_q    = op_q_r;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;
  assign state_dbg   = state;

endmodule

// File: doc/templatized_alu_sequencer.md
TEMPLATIZED_ALU_SEQUENCER -- requirements
Module: templatized_alu_sequencer

Interface
REQ-001 SHALL have parameter OP_W, default 3: opcode width, at least 3.
REQ-002 SHALL have parameter SHIFT_CYCLES, default 4: shift-group execution length in cycles, at least 1.
REQ-003 SHALL have parameter CNT_W, default 16: width of the performance counter.
REQ-004 SHALL have clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have in_valid, input, 1 bit: an opcode is offered.
REQ-007 SHALL have in_ready, output, 1 bit: the sequencer accepts an opcode this cycle.
REQ-008 SHALL have op_code, input, OP_W bits: the offered opcode.
REQ-009 SHALL have flush, input, 1 bit: synchronous abort.
REQ-010 SHALL have en, output, 2 bits: group enables; en[1] is the logic group, en[0] is the shift group.
REQ-011 SHALL have op_q, output, OP_W bits: opcode currently executing.
REQ-012 SHALL have busy, output, 1 bit: the sequencer is in EXEC.
REQ-013 SHALL have done, output, 1 bit: one-cycle pulse on the last execution cycle.
REQ-014 SHALL have illegal, output, 1 bit: one-cycle pulse after an illegal opcode is accepted.
REQ-015 SHALL have op_count, output, CNT_W bits: count of completed operations.

Function
REQ-016 SHALL decode opcodes as follows:
- 0 (XOR) is the logic group, length 1 cycle.
- 1 (SLL), 2 (SAR), 3 (ROTL) and 4 (ROTR) are the shift group, length SHIFT_CYCLES cycles.
- All other values are illegal.
REQ-017 SHALL implement two states, IDLE and EXEC, plus a down-counter of width $clog2(SHIFT_CYCLES+1).
REQ-018 SHALL drive in_ready = !flush && (state==IDLE || done).
REQ-019 SHALL treat a handshake as in_valid && in_ready, sampled at rising clk.
- A legal handshake at cycle T SHALL put the sequencer in EXEC from cycle T+1.
- en SHALL then be one-hot for its group from T+1 through T+L, where L is the group length.
- op_q SHALL equal the opcode over the same cycles.
- done SHALL be high only at cycle T+L.
REQ-020 SHALL hold en and op_q stable throughout EXEC, regardless of op_code changes.
REQ-021 SHALL support back-to-back issue: a handshake on a done cycle starts the next operation at the following cycle, with no IDLE bubble.
REQ-022 SHALL drive en = 0 and busy = 0 whenever the state is IDLE.
REQ-023 SHALL handle an illegal handshake this way:
- The state stays IDLE and en stays 0.
- illegal is high the next cycle for exactly one cycle.
- No done pulse is produced and op_count does not change.
REQ-024 SHALL make flush high at a clock edge force IDLE, with en = 0 from the next cycle.
- That cycle produces no done and no illegal pulse.
- The in-flight operation is discarded.
REQ-025 SHALL give flush priority over a simultaneous in_valid; that op is not accepted, because in_ready is 0.
REQ-026 SHALL give a 1-cycle XOR op busy = 1 and done = 1 in the same single cycle.
REQ-027 SHALL ignore in_valid while in_ready is low; holding it high stalls without side effects.

Reset
REQ-028 SHALL force, on asserted rst_n and independent of clk: state IDLE, counter 0, en 0, op_q 0, busy 0, done 0, illegal 0, op_count 0.
REQ-029 SHALL abandon any operation in progress when reset is asserted mid-operation, with no done pulse after release.
REQ-030 SHALL drive in_ready = 1 in the first cycle after rst_n deasserts, unless flush is high.

Configuration
REQ-031 With ALU_SEQ_PERF_EN defined, op_count SHALL increment by 1 on every done pulse and saturate at 2^CNT_W-1.
- flush SHALL not clear op_count.
REQ-032 Without ALU_SEQ_PERF_EN, op_count SHALL be tied to 0 and no counter register shall be synthesised.

Verification (SHIFT_CYCLES=4)
REQ-033 Reset release, then XOR (0) offered at T: en=2'b10 and done=1 at T+1 only; in_ready=1 at T+1.
REQ-034 SAR (2) at T: en=2'b01 during T+1..T+4, op_q=2, done at T+4 only; in_ready low T+1..T+3.
REQ-035 SLL offered at T, then ROTR offered during the stall: ROTR accepted at T+4 (the done cycle), en=2'b01 during T+5..T+8, no gap.
REQ-036 Opcode 7 at T: illegal=1 at T+1, en=0 throughout, op_count unchanged, in_ready stays 1.
REQ-037 ROTL at T, flush at T+2: en=0 and busy=0 from T+3, no done; flush coinciding with in_valid is not accepted.
REQ-038 PERF_EN with CNT_W=2: five XOR ops give op_count sequence 1,2,3,3,3; rst_n low mid-SAR clears all outputs immediately.
